// File: rtl/sc_sched_pkg.sv
// Shared definitions for the stochastic-stream delay-line scheduler.
//   state_e     : scheduler FSM encoding
//   TAG_CTRL_W  : control bits in a tag; tag layout MSB->LSB is {valid, last, id}
//   clog2       : elaboration-time ceil(log2) helper
package sc_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned TAG_CTRL_W = 2;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'(1) << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sc_delay_scheduler_if.sv
// Requester / delay-line / output bundle of the delay-line scheduler.
//   slave  : scheduler side (takes req/req_len/req_bit/sr_data_out, drives the rest)
//   master : environment side (requesters, delay line and output consumer)
interface sc_delay_scheduler_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LEN_W = 10,
  parameter int unsigned ID_W  = sc_sched_pkg::clog2(NREQ)
);

  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] req_len;
  logic [NREQ-1:0]       req_bit;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       bit_taken;
  logic                  sr_data_in;
  logic                  sr_data_out;
  logic                  out_bit;
  logic                  out_valid;
  logic [ID_W-1:0]       out_id;
  logic [NREQ-1:0]       done;

  modport slave (
    input  req, req_len, req_bit, sr_data_out,
    output grant, bit_taken, sr_data_in, out_bit, out_valid, out_id, done
  );

  modport master (
    output req, req_len, req_bit, sr_data_out,
    input  grant, bit_taken, sr_data_in, out_bit, out_valid, out_id, done
  );

endinterface

// File: rtl/sc_tag_pipe.sv
// Register chain carrying per-bit tags alongside the external delay line.
//   clk, rst : clock, async active-low reset (all stages clear to 0)
//   d        : tag entering the chain this cycle
//   q        : tag leaving the chain (entered DEPTH cycles ago)
module sc_tag_pipe #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Shift by one stage every cycle
  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
    end
  end

  assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/sc_delay_scheduler.sv
// Shares one external 1-bit delay line among NREQ stochastic bitstream sources.
// A round-robin winner owns the line for a whole stream; its bits are tagged
// {valid,last,id} and the tags travel in a matching pipe so the delayed bits
// come out with valid, id and a per-requester done pulse.
//   clk, rst      : clock, async active-low reset
//   bus.req/req_len/req_bit       : requester handshake, length and data
//   bus.grant/bit_taken           : current owner / bit consumed this cycle
//   bus.sr_data_in/sr_data_out    : to / from the delay line
//   bus.out_bit/out_valid/out_id/done : delayed output stream
module sc_delay_scheduler
  import sc_sched_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 10
) (
  input logic                 clk,
  input logic                 rst,
  sc_delay_scheduler_if.slave bus
);

  localparam int unsigned ID_W  = clog2(NREQ);
  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned TAG_W = ID_W + TAG_CTRL_W;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0] gid_q, gid_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  idx;
  logic [LEN_W-1:0] len_sel;
  logic             last;
  logic             sr_in;
  logic [TAG_W-1:0] tag_in, tag_out;
  logic             out_valid, out_last;
  logic [ID_W-1:0]  out_id;
  logic [NREQ-1:0]  done_c;

  // Round-robin search: first asserted req at or after rr_q, wrapping
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = ID_W'((32'(rr_q) + k) % NREQ);
      if (!win_found && bus.req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign len_sel = bus.req_len[32'(win_id)*LEN_W +: LEN_W];

  // Next state: arbitrate in IDLE, stream bits in RUN
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gid_d   = gid_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    sr_in   = 1'b0;
    last    = 1'b0;
    tag_in  = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d = NREQ'(1) << win_id;
          gid_d   = win_id;
          // A zero length field stands for the full 2^LEN_W stream
          cnt_d   = (len_sel == '0) ? (CNT_W'(1) << LEN_W) : CNT_W'(len_sel);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sr_in  = bus.req_bit[gid_q];
        // Dropping req ends the stream; the current bit still counts
        last   = (cnt_q == CNT_W'(1)) || !bus.req[gid_q];
        tag_in = {1'b1, last, gid_q};
        cnt_d  = cnt_q - CNT_W'(1);
        if (last) begin
          grant_d = '0;
          rr_d    = ID_W'((32'(gid_q) + 1) % NREQ);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gid_q   <= gid_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  sc_tag_pipe #(
    .WIDTH(TAG_W),
    .DEPTH(DEPTH)
  ) u_tag_pipe (
    .clk(clk),
    .rst(rst),
    .d  (tag_in),
    .q  (tag_out)
  );

  assign out_valid = tag_out[TAG_W-1];
  assign out_last  = tag_out[TAG_W-2];
  assign out_id    = tag_out[ID_W-1:0];

  // Done pulse for the owner of the final bit at the output
  always_comb begin
    done_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      done_c[i] = out_valid & out_last & (32'(out_id) == i);
    end
  end

  assign bus.grant      = grant_q;
  assign bus.bit_taken  = grant_q & {NREQ{state_q == ST_RUN}};
  assign bus.sr_data_in = sr_in;
  assign bus.out_bit    = bus.sr_data_out;
  assign bus.out_valid  = out_valid;
  assign bus.out_id     = out_id;
  assign bus.done       = done_c;

endmodule
